ring_endpoint: RTL

//  Core-side network interface for one ring node: the opposite end of the ring's per-node inject/eject ports.

---
 rtl/ring_endpoint_pkg.sv | 19 +
 rtl/ring_endpoint_if.sv | 31 +++
 rtl/ring_ep_fifo.sv | 53 +++++
 rtl/ring_endpoint.sv | 113 +++++++++++
 4 files changed

// File: rtl/ring_endpoint_pkg.sv
// Shared types for the ring endpoint: packet layout, counter widths and the
// inject-side FSM state encoding.
package ring_endpoint_pkg;
    localparam int NODE_ID_W = 8;
    localparam int CNT_W     = 16;
    localparam int DATA_W    = 128;

    typedef struct packed {
        logic [NODE_ID_W-1:0] src;
        logic [NODE_ID_W-1:0] dest;
        logic [DATA_W-1:0]    data;
    } pkt_t;

    typedef enum logic [1:0] {
        INJ_IDLE    = 2'd0,
        INJ_OFFER   = 2'd1,
        INJ_STARVED = 2'd2
    } inj_state_t;
endpackage

// File: rtl/ring_endpoint_if.sv
// Core-side and ring-side handshake bundle of one ring endpoint.
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready (or accept) are both 1. The producer holds valid and its packet steady
// until that edge. The ring receive path (ring_rx_valid) has no backpressure:
// every pulse is a packet that must be taken or dropped in that cycle.
interface ring_endpoint_if;
    import ring_endpoint_pkg::*;

    logic core_valid;
    pkt_t core_pkt;
    logic core_ready;
    logic ring_valid;
    pkt_t ring_pkt;
    logic ring_accept;
    logic ring_rx_valid;
    pkt_t ring_rx_pkt;
    logic deliver_valid;
    pkt_t deliver_pkt;
    logic deliver_ready;

    modport slave (
        input  core_valid, core_pkt, ring_accept, ring_rx_valid, ring_rx_pkt, deliver_ready,
        output core_ready, ring_valid, ring_pkt, deliver_valid, deliver_pkt
    );

    modport master (
        output core_valid, core_pkt, ring_accept, ring_rx_valid, ring_rx_pkt, deliver_ready,
        input  core_ready, ring_valid, ring_pkt, deliver_valid, deliver_pkt
    );
endinterface

// File: rtl/ring_ep_fifo.sv
// Synchronous FIFO with combinational head. A push into a full FIFO is taken
// when a pop happens in the same cycle (occupancy unchanged).
module ring_ep_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ring_endpoint.sv
// Core-side network interface of one ring node: injection queue with starvation
// watch, ejection queue with overflow/misroute flags, and traffic counters.
module ring_endpoint
    import ring_endpoint_pkg::*;
#(
    parameter int unsigned NODE_ID   = 0,
    parameter int unsigned INJ_DEPTH = 4,
    parameter int unsigned EJ_DEPTH  = 8,
    parameter int unsigned STALL_MAX = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    ring_endpoint_if.slave            bus,
    output logic                      starve,
    output logic                      ej_overflow,
    output logic                      misroute,
    output logic [CNT_W-1:0]          tx_count,
    output logic [CNT_W-1:0]          rx_count,
    output inj_state_t                inj_state,
    output logic [$clog2(EJ_DEPTH):0] ej_level
);
    localparam int IAW = $clog2(INJ_DEPTH);
    localparam int CW  = $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0]        STALL_LIM = CW'(STALL_MAX);
    localparam logic [CW-1:0]        STALL_PRE = CW'(STALL_MAX - 1);
    localparam logic [NODE_ID_W-1:0] NODE      = NODE_ID_W'(NODE_ID);

    pkt_t          inj_din;
    pkt_t          inj_dout;
    pkt_t          ej_dout;
    logic          inj_full, inj_empty, inj_push, inj_pop, inj_last;
    logic [IAW:0]  inj_count;
    logic          ej_full, ej_empty, ej_pop, ej_take;
    logic [CW-1:0] stall_cnt;

    always_comb begin
        inj_din     = bus.core_pkt;
        inj_din.src = NODE;
    end

    assign bus.core_ready    = ~inj_full;
    assign bus.ring_valid    = ~inj_empty;
    assign bus.ring_pkt      = inj_dout;
    assign bus.deliver_valid = ~ej_empty;
    assign bus.deliver_pkt   = ej_dout;

    assign inj_push = bus.core_valid & ~inj_full;
    assign inj_pop  = bus.ring_accept & ~inj_empty;
    // The queue drains on this edge only if the popped head was the last entry.
    assign inj_last = (inj_count == {{IAW{1'b0}}, 1'b1}) & ~inj_push;
    assign ej_pop   = bus.deliver_ready & ~ej_empty;
    assign ej_take  = bus.ring_rx_valid & (~ej_full | ej_pop);

    ring_ep_fifo #(.WIDTH($bits(pkt_t)), .DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inj_push),
        .pop   (inj_pop),
        .din   (inj_din),
        .dout  (inj_dout),
        .full  (inj_full),
        .empty (inj_empty),
        .count (inj_count)
    );

    ring_ep_fifo #(.WIDTH($bits(pkt_t)), .DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.ring_rx_valid),
        .pop   (ej_pop),
        .din   (bus.ring_rx_pkt),
        .dout  (ej_dout),
        .full  (ej_full),
        .empty (ej_empty),
        .count (ej_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            inj_state <= INJ_IDLE;
            stall_cnt <= '0;
            starve    <= 1'b0;
            tx_count  <= '0;
        end else if (inj_pop) begin
            tx_count  <= tx_count + 1'b1;
            stall_cnt <= '0;
            inj_state <= inj_last ? INJ_IDLE : INJ_OFFER;
        end else if (~inj_empty) begin
            if (stall_cnt != STALL_LIM) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == STALL_PRE || inj_state == INJ_STARVED) begin
                inj_state <= INJ_STARVED;
                starve    <= 1'b1;
            end else begin
                inj_state <= INJ_OFFER;
            end
        end else begin
            inj_state <= INJ_IDLE;
            stall_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_count    <= '0;
            ej_overflow <= 1'b0;
            misroute    <= 1'b0;
        end else begin
            if (ej_take) rx_count <= rx_count + 1'b1;
            if (bus.ring_rx_valid & ~ej_take) ej_overflow <= 1'b1;
            if (bus.ring_rx_valid && bus.ring_rx_pkt.dest != NODE) misroute <= 1'b1;
        end
    end
endmodule
